// File: rtl/expr_display_pkg.sv
// Shared types and constants for the expression display block.
//   state_t              : controller states
//   MINUS/PLUS/EQ/BLANK  : active-low 7-segment patterns {dp,g,f,e,d,c,b,a}
//   ceil_div4            : number of hex digits needed for a bit width
package expr_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam logic [7:0] MINUS = 8'hBF;
  localparam logic [7:0] PLUS  = 8'h8F;
  localparam logic [7:0] EQ    = 8'hB7;
  localparam logic [7:0] BLANK = 8'hFF;

  function automatic int ceil_div4(input int w);
    return (w + 3) / 4;
  endfunction

endpackage

// File: rtl/expr_display_if.sv
// Command/status bundle for expr_display.
//   start, clear, a, b, s : requests and operands (master -> slave)
//   busy, done, neg, hex  : status and 7-segment drive (slave -> master)
interface expr_display_if #(
  parameter int WIDTH      = 4,
  parameter int NUM_DIGITS = 6
);
  logic                    start;
  logic                    clear;
  logic [WIDTH-1:0]        a;
  logic [WIDTH-1:0]        b;
  logic                    s;
  logic                    busy;
  logic                    done;
  logic                    neg;
  logic [8*NUM_DIGITS-1:0] hex;

  modport master (output start, clear, a, b, s,
                  input  busy, done, neg, hex);
  modport slave  (input  start, clear, a, b, s,
                  output busy, done, neg, hex);
endinterface

// File: rtl/hex_to_seg.sv
// One hex nibble to an active-low 7-segment pattern, dp always off.
//   nib : 4-bit value
//   seg : {dp,g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seg (
  input  logic [3:0] nib,
  output logic [7:0] seg
);
  always_comb begin
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
  end
endmodule

// File: rtl/expr_display.sv
// Latches two operands, adds or subtracts them and renders
// "a op b = [-]result" on a row of 7-segment displays, scrolling the
// message when it is longer than the row.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start  : latch a, b, s and compute (ignored while computing)
//   bus.clear  : back to IDLE, displays blank (wins over start)
//   bus.busy   : high in COMPUTE
//   bus.done   : one-cycle pulse on entry to SHOW
//   bus.neg    : negative result, valid in SHOW
//   bus.hex    : display k at hex[8k+7:8k], k = NUM_DIGITS-1 leftmost
module expr_display
  import expr_display_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NUM_DIGITS = 6,
  parameter int SCROLL_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  expr_display_if.slave      bus
);
  localparam int D      = ceil_div4(WIDTH);
  localparam int R      = ceil_div4(WIDTH + 1);
  localparam int L      = 2 * D + R + 3;
  localparam bit SCROLL = (L > NUM_DIGITS);
  // Ring holds the message followed by blanks; sized so every display
  // index stays in range whether or not the message scrolls.
  localparam int RL     = SCROLL ? L + 1 : NUM_DIGITS;
  localparam int PW     = $clog2(L + 1);
  localparam int CW     = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  state_t               state, state_d;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 s_q, neg_q, done_q, load;
  logic [WIDTH:0]       res_q, res_d;
  logic signed [WIDTH:0] diff;
  logic                 neg_d;
  logic [PW-1:0]        pos;
  logic [CW-1:0]        cnt;
  logic [4*D-1:0]       a_pad, b_pad;
  logic [4*R-1:0]       r_pad;
  logic [8*D-1:0]       a_segv, b_segv;
  logic [8*R-1:0]       r_segv;
  logic [8*RL-1:0]      ring;
  logic [8*NUM_DIGITS-1:0] hex_d;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.start) state_d = COMPUTE;
      COMPUTE: state_d = SHOW;
      SHOW:    if (bus.start) state_d = COMPUTE;
      default: state_d = IDLE;
    endcase
    if (bus.clear) state_d = IDLE;
  end

  assign load = bus.start && !bus.clear && (state != COMPUTE);

  // Unsigned add, or magnitude of the signed difference plus a sign flag.
  always_comb begin
    diff  = $signed({1'b0, a_q}) - $signed({1'b0, b_q});
    res_d = {1'b0, a_q} + {1'b0, b_q};
    neg_d = 1'b0;
    if (s_q) begin
      if (diff < 0) begin
        neg_d = 1'b1;
        res_d = $unsigned(-diff);
      end else begin
        res_d = $unsigned(diff);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= 1'b0;
      res_q  <= '0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
      pos    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      done_q <= (state == COMPUTE) && !bus.clear;
      if (load) begin
        a_q <= bus.a;
        b_q <= bus.b;
        s_q <= bus.s;
      end
      if (state == COMPUTE && !bus.clear) begin
        res_q <= res_d;
        neg_q <= neg_d;
      end
      if (state == COMPUTE) begin
        pos <= '0;
        cnt <= '0;
      end else if (state == SHOW && SCROLL) begin
        if (cnt == CW'(SCROLL_DIV - 1)) begin
          cnt <= '0;
          pos <= (pos == PW'(L)) ? '0 : pos + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign a_pad = (4*D)'(a_q);
  assign b_pad = (4*D)'(b_q);
  assign r_pad = (4*R)'(res_q);

  for (genvar k = 0; k < D; k++) begin : g_ab
    hex_to_seg u_a (.nib(a_pad[4*k +: 4]), .seg(a_segv[8*k +: 8]));
    hex_to_seg u_b (.nib(b_pad[4*k +: 4]), .seg(b_segv[8*k +: 8]));
  end
  for (genvar k = 0; k < R; k++) begin : g_r
    hex_to_seg u_r (.nib(r_pad[4*k +: 4]), .seg(r_segv[8*k +: 8]));
  end

  // ring[8*i +: 8] is message symbol i, left to right, most significant digit first.
  always_comb begin
    ring = {RL{BLANK}};
    for (int i = 0; i < D; i++) begin
      ring[8*i +: 8]           = a_segv[8*(D-1-i) +: 8];
      ring[8*(D+1+i) +: 8]     = b_segv[8*(D-1-i) +: 8];
    end
    ring[8*D +: 8]             = s_q ? MINUS : PLUS;
    ring[8*(2*D+1) +: 8]       = EQ;
    ring[8*(2*D+2) +: 8]       = neg_q ? MINUS : BLANK;
    for (int i = 0; i < R; i++) begin
      ring[8*(2*D+3+i) +: 8]   = r_segv[8*(R-1-i) +: 8];
    end
  end

  always_comb begin
    int idx;
    idx   = 0;
    hex_d = {NUM_DIGITS{BLANK}};
    if (state == SHOW) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        idx = int'(pos) + j;
        if (SCROLL && idx >= L + 1) idx = idx - (L + 1);
        hex_d[8*(NUM_DIGITS-1-j) +: 8] = ring[8*idx +: 8];
      end
    end
  end

  assign bus.hex  = hex_d;
  assign bus.busy = (state == COMPUTE);
  assign bus.done = done_q;
  assign bus.neg  = (state == SHOW) && neg_q;

endmodule

// File: tb/tb_expr_display.sv
module tb_expr_display;
  localparam int WIDTH = 4;
  localparam int ND    = 6;
  localparam int SD    = 4;
  localparam logic [47:0] ALL_BLANK = 48'hFFFFFFFFFFFF;

  typedef struct packed {
    logic [47:0] hex;
    logic        neg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [7:0] hs [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  expr_display_if #(.WIDTH(WIDTH), .NUM_DIGITS(ND)) bus ();

  expr_display #(.WIDTH(WIDTH), .NUM_DIGITS(ND), .SCROLL_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: 7-symbol message plus one blank, rotated by pos.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                 input logic s, input int pos);
    logic [4:0] r;
    logic       n;
    logic [7:0] sym [8];
    exp_t       e;
    n = 1'b0;
    if (!s)          r = {1'b0, a} + {1'b0, b};
    else if (a >= b) r = {1'b0, a} - {1'b0, b};
    else begin       r = {1'b0, b} - {1'b0, a}; n = 1'b1; end
    sym[0] = hs[a];
    sym[1] = s ? 8'hBF : 8'h8F;
    sym[2] = hs[b];
    sym[3] = 8'hB7;
    sym[4] = n ? 8'hBF : 8'hFF;
    sym[5] = hs[{3'b000, r[4]}];
    sym[6] = hs[r[3:0]];
    sym[7] = 8'hFF;
    for (int j = 0; j < 6; j++) e.hex[8*(5-j) +: 8] = sym[3'((pos + j) % 8)];
    e.neg = n;
    return e;
  endfunction

  task automatic do_start(input logic [3:0] a, input logic [3:0] b, input logic s);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.s = s; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_done: done never rose within 8 cycles");
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.hex !== ALL_BLANK) begin errors++; $display("FAIL reset_hex got %h want %h", bus.hex, ALL_BLANK); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.neg !== 1'b0) begin errors++; $display("FAIL reset_neg got %b want 0", bus.neg); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sub_neg();
    exp_t e;
    bit ok;
    sb.push_back(model(4'd3, 4'd5, 1'b1, 0));
    do_start(4'd3, 4'd5, 1'b1);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL subneg_busy got %b want 1", bus.busy); end
    wait_done(ok);
    e = sb.pop_front();
    if (ok) begin
      checks++; if (bus.hex !== e.hex) begin errors++; $display("FAIL subneg_hex got %h want %h", bus.hex, e.hex); end
      checks++; if (bus.hex !== 48'hB0BF92B7BFC0) begin errors++; $display("FAIL subneg_lit got %h want B0BF92B7BFC0", bus.hex); end
      checks++; if (bus.neg !== e.neg) begin errors++; $display("FAIL subneg_neg got %b want %b", bus.neg, e.neg); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL subneg_busy_show got %b want 0", bus.busy); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL subneg_done_pulse got %b want 0", bus.done); end
      repeat (3) @(negedge clk);
      checks++; if (bus.hex !== 48'hBF92B7BFC0A4) begin errors++; $display("FAIL scroll1 got %h want BF92B7BFC0A4", bus.hex); end
      repeat (4) @(negedge clk);
      e = model(4'd3, 4'd5, 1'b1, 2);
      checks++; if (bus.hex !== e.hex) begin errors++; $display("FAIL scroll2 got %h want %h", bus.hex, e.hex); end
      repeat (24) @(negedge clk);
      checks++; if (bus.hex !== 48'hB0BF92B7BFC0) begin errors++; $display("FAIL scroll_wrap got %h want B0BF92B7BFC0", bus.hex); end
      checks++; if (bus.neg !== 1'b1) begin errors++; $display("FAIL scroll_neg got %b want 1", bus.neg); end
    end
  endtask

  task automatic test_add();
    exp_t e;
    bit ok;
    sb.push_back(model(4'd9, 4'd8, 1'b0, 0));
    do_start(4'd9, 4'd8, 1'b0);
    wait_done(ok);
    e = sb.pop_front();
    if (ok) begin
      checks++; if (bus.hex !== e.hex) begin errors++; $display("FAIL add_hex got %h want %h", bus.hex, e.hex); end
      checks++; if (bus.hex !== 48'h908F80B7FFF9) begin errors++; $display("FAIL add_lit got %h want 908F80B7FFF9", bus.hex); end
      checks++; if (bus.neg !== 1'b0) begin errors++; $display("FAIL add_neg got %b want 0", bus.neg); end
    end
  endtask

  task automatic test_equal();
    exp_t e;
    bit ok;
    sb.push_back(model(4'd7, 4'd7, 1'b1, 0));
    do_start(4'd7, 4'd7, 1'b1);
    wait_done(ok);
    e = sb.pop_front();
    if (ok) begin
      checks++; if (bus.hex !== e.hex) begin errors++; $display("FAIL eq_hex got %h want %h", bus.hex, e.hex); end
      checks++; if (bus.neg !== 1'b0) begin errors++; $display("FAIL eq_neg got %b want 0", bus.neg); end
      repeat (4) @(negedge clk);
      checks++; if (bus.hex !== 48'hBFF8B7FFC0C0) begin errors++; $display("FAIL eq_result got %h want BFF8B7FFC0C0", bus.hex); end
    end
  endtask

  task automatic test_start_during_compute();
    exp_t e;
    sb.push_back(model(4'd1, 4'd2, 1'b0, 0));
    @(negedge clk);
    bus.a = 4'd1; bus.b = 4'd2; bus.s = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", bus.busy); end
    bus.a = 4'hF; bus.b = 4'hF; bus.s = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e = sb.pop_front();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_done got %b want 1", bus.done); end
    checks++; if (bus.hex !== e.hex) begin errors++; $display("FAIL ign_hex got %h want %h", bus.hex, e.hex); end
    checks++; if (bus.neg !== e.neg) begin errors++; $display("FAIL ign_neg got %b want %b", bus.neg, e.neg); end
  endtask

  task automatic test_clear_start();
    @(negedge clk);
    bus.a = 4'd5; bus.b = 4'd1; bus.s = 1'b0; bus.start = 1'b1; bus.clear = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.clear = 1'b0;
    checks++; if (bus.hex !== ALL_BLANK) begin errors++; $display("FAIL clr_hex got %h want %h", bus.hex, ALL_BLANK); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", bus.busy); end
    checks++; if (bus.neg !== 1'b0) begin errors++; $display("FAIL clr_neg got %b want 0", bus.neg); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL clr_done cycle %0d got %b want 0", i, bus.done); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    logic [3:0] a, b;
    logic s;
    for (int n = 0; n < 6; n++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      s = 1'($urandom_range(0, 1));
      sb.push_back(model(a, b, s, 0));
      do_start(a, b, s);
      wait_done(ok);
      e = sb.pop_front();
      if (ok) begin
        checks++; if (bus.hex !== e.hex) begin errors++; $display("FAIL b2b_hex a=%h b=%h s=%b got %h want %h", a, b, s, bus.hex, e.hex); end
        checks++; if (bus.neg !== e.neg) begin errors++; $display("FAIL b2b_neg a=%h b=%h s=%b got %b want %b", a, b, s, bus.neg, e.neg); end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.hex !== ALL_BLANK) begin errors++; $display("FAIL rstmid_hex got %h want %h", bus.hex, ALL_BLANK); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.neg !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctl got busy=%b done=%b neg=%b want 0 0 0", bus.busy, bus.done, bus.neg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.hex !== ALL_BLANK || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got hex=%h busy=%b want all FF, 0", bus.hex, bus.busy);
    end
    do_start(4'd2, 4'd3, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstcomp_busy got %b want 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstcomp_done cycle %0d got %b want 0", i, bus.done); end
    end
    sb.push_back(model(4'd2, 4'd3, 1'b0, 0));
    do_start(4'd2, 4'd3, 1'b0);
    wait_done(ok);
    e = sb.pop_front();
    if (ok) begin
      checks++; if (bus.hex !== e.hex) begin errors++; $display("FAIL rstcomp_restart got %h want %h", bus.hex, e.hex); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.s     = 1'b0;
    test_reset();
    test_sub_neg();
    test_add();
    test_equal();
    test_start_during_compute();
    test_clear_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_display.md
EXPR_DISPLAY -- requirements
Module: expr_display

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, 1..16.
REQ-002 Parameter NUM_DIGITS, default 6: number of 7-segment displays driven.
REQ-003 Parameter SCROLL_DIV, default 25_000_000: clocks per scroll step, >=1.
REQ-004 clk  input  1: single clock; all state on rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 start  input  1: request to latch a, b, s and compute.
REQ-007 clear  input  1: return to IDLE and blank the displays.
REQ-008 a, b  input  WIDTH each: unsigned operands.
REQ-009 s  input  1: 0 = add, 1 = subtract (a-b).
REQ-010 busy  output  1: high while in COMPUTE.
REQ-011 done  output  1: one-cycle pulse on entry to SHOW.
REQ-012 neg  output  1: result negative (subtract with a<b), held during SHOW.
REQ-013 hex  output  8*NUM_DIGITS: active-low segments {dp,g,f,e,d,c,b,a} per display; hex[8k+7:8k] is display k, k=NUM_DIGITS-1 leftmost.

Function
REQ-014 States IDLE, COMPUTE, SHOW; IDLE->COMPUTE on start; COMPUTE->SHOW after exactly one cycle; SHOW->COMPUTE on start (restart with new operands).
REQ-015 start sampled at cycle 0 -> busy high cycle 1 -> SHOW and done high cycle 2; start during COMPUTE ignored.
REQ-016 clear in any state -> IDLE next cycle; clear and start together: clear wins.
REQ-017 Add: result = a+b in WIDTH+1 bits, neg=0; subtract a>=b: result=a-b, neg=0; subtract a<b: result=b-a, neg=1.
REQ-018 D=ceil(WIDTH/4) operand digits, R=ceil((WIDTH+1)/4) result digits, message length L=2D+R+3.
REQ-019 Message, left to right: a (D hex digits, MSD first), op symbol (PLUS if s=0, MINUS if s=1), b (D hex digits), EQ, prefix (MINUS if neg else BLANK), result (R hex digits, leading zeros shown).
REQ-020 If L<=NUM_DIGITS: message left-justified, unused displays BLANK, no scrolling.
REQ-021 If L>NUM_DIGITS: ring of L+1 symbols (message then one BLANK); display NUM_DIGITS-1-j shows ring[(pos+j) mod (L+1)].
REQ-022 pos=0 and scroll counter=0 on every entry to SHOW; pos increments every SCROLL_DIV cycles, wraps from L to 0.
REQ-023 Encodings: hex digits 0-F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E; MINUS=BF, PLUS=8F, EQ=B7, BLANK=FF; dp always off.
REQ-024 In IDLE and COMPUTE all displays BLANK, neg=0.

Reset
REQ-025 rst_n low asynchronously forces IDLE, busy=0, done=0, neg=0, all hex=FF, pos=0, counter=0, latched operands=0.
REQ-026 Reset asserted mid-COMPUTE or mid-scroll abandons the operation; after release the block waits for a new start.

Structure
REQ-027 Package expr_display_pkg holds state enum and the segment constants MINUS, PLUS, EQ, BLANK.
REQ-028 One sub-module hex_to_seg (4-bit nibble -> 8-bit active-low pattern), instantiated per digit.

Verification (WIDTH=4, NUM_DIGITS=6, SCROLL_DIV=4)
REQ-029 Reset: rst_n=0 mid-SHOW -> same timestep hex=FFFFFFFFFFFF, busy=0, done=0, neg=0.
REQ-030 a=3,b=5,s=1, start 1 cycle -> busy cycle 1, done cycle 2, neg=1, hex5..0 = B0 BF 92 B7 BF C0.
REQ-031 Continue REQ-030 -> after 4 cycles hex5..0 = BF 92 B7 BF C0 A4; after 32 cycles back to B0 BF 92 B7 BF C0 (wrap).
REQ-032 a=9,b=8,s=0 -> result 0x11, neg=0, hex5..0 = 90 8F 80 B7 FF F9.
REQ-033 start and clear together in SHOW -> IDLE, all hex=FF, no done pulse; start during COMPUTE -> ignored, operands unchanged.
REQ-034 a=7,b=7,s=1 -> neg=0, result shown as C0 C0, prefix BLANK.
